// File: rtl/bubble_sorter_pkg.sv
// Shared definitions for the bubble sorter: FSM state encoding.
package bubble_sorter_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    CMP  = 3'd3,
    WRA  = 3'd4,
    WRB  = 3'd5,
    ADV  = 3'd6,
    DONE = 3'd7
  } state_t;

endpackage

// File: rtl/sort_ram.sv
// Single-port RAM with registered read (old data on read-during-write).
module sort_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic [AW-1:0]    address,
  input  logic [WIDTH-1:0] data,
  input  logic             wren,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write on wren, always register the addressed word for the 1-cycle read
  always_ff @(posedge clock) begin
    if (wren) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

endmodule

// File: rtl/bubble_sorter.sv
// In-place bubble sorter over a single-port RAM with host load/read port,
// start/busy/done handshake, early exit on a swap-free pass and a
// saturating swap counter.
module bubble_sorter #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  parameter  int CNTW  = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             C,
  input  logic             nRST,
  input  logic             start,
  input  logic             desc,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [CNTW-1:0]  swaps
);

  import bubble_sorter_pkg::*;

  localparam logic [AW-1:0] LAST_INIT = AW'((DEPTH > 1) ? DEPTH - 2 : 0);

  state_t           state;
  state_t           state_nx;
  logic [AW-1:0]    idx;
  logic [AW-1:0]    idx_p1;
  logic [AW-1:0]    last;
  logic             sw;
  logic             desc_q;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] q;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_din;
  logic             mem_we;
  logic             ooo;
  logic             more_pairs;
  logic             finish_pass;
  logic             host_sel_d;
  logic [WIDTH-1:0] rd_hold;

  assign idx_p1      = idx + AW'(1);
  assign ooo         = desc_q ? (a_reg < q) : (a_reg > q);
  assign more_pairs  = (idx < last);
  assign finish_pass = !sw || (last == '0);

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  sort_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock   (C),
    .address (mem_addr),
    .data    (mem_din),
    .wren    (mem_we),
    .q       (q)
  );

  // State register; reset returns to IDLE immediately, abandoning any sort
  always_ff @(posedge C) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and RAM port steering (host owns the port only in IDLE)
  always_comb begin
    state_nx = state;
    mem_addr = idx;
    mem_din  = b_reg;
    mem_we   = 1'b0;
    case (state)
      IDLE: begin
        mem_addr = wr_en ? wr_addr : rd_addr;
        mem_din  = wr_data;
        mem_we   = wr_en & nRST;
        if (start) begin
          state_nx = (DEPTH == 1) ? DONE : RDA;
        end
      end
      RDA: begin
        mem_addr = idx;
        state_nx = RDB;
      end
      RDB: begin
        mem_addr = idx_p1;
        state_nx = CMP;
      end
      CMP: begin
        state_nx = ooo ? WRA : ADV;
      end
      WRA: begin
        mem_addr = idx;
        mem_din  = b_reg;
        mem_we   = nRST;
        state_nx = WRB;
      end
      WRB: begin
        mem_addr = idx_p1;
        mem_din  = a_reg;
        mem_we   = nRST;
        state_nx = ADV;
      end
      ADV: begin
        if (more_pairs) begin
          state_nx = RDA;
        end else if (finish_pass) begin
          state_nx = DONE;
        end else begin
          state_nx = RDA;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Pass bookkeeping: pair index, pass limit, swap flag, swap count, direction
  always_ff @(posedge C) begin
    if (!nRST) begin
      idx    <= '0;
      last   <= '0;
      sw     <= 1'b0;
      swaps  <= '0;
      desc_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx    <= '0;
            last   <= LAST_INIT;
            sw     <= 1'b0;
            swaps  <= '0;
            desc_q <= desc;
          end
        end
        WRB: begin
          sw <= 1'b1;
          if (swaps != '1) begin
            swaps <= swaps + CNTW'(1);
          end
        end
        ADV: begin
          if (more_pairs) begin
            idx <= idx_p1;
          end else if (!finish_pass) begin
            idx  <= '0;
            last <= last - AW'(1);
            sw   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Capture the two elements of the current pair as they come out of the RAM
  always_ff @(posedge C) begin
    if (state == RDB) begin
      a_reg <= q;
    end
    if (state == CMP) begin
      b_reg <= q;
    end
  end

  // Remember the last host-side read so rd_data stays put while the FSM owns the RAM
  always_ff @(posedge C) begin
    if (!nRST) begin
      host_sel_d <= 1'b0;
      rd_hold    <= '0;
    end else begin
      host_sel_d <= (state == IDLE);
      if (host_sel_d) begin
        rd_hold <= q;
      end
    end
  end

  assign rd_data = host_sel_d ? q : rd_hold;

endmodule

// File: tb/tb_bubble_sorter.sv
// Directed, table-driven bench for bubble_sorter: main 16x8 instance,
// a CNTW=4 instance for counter saturation and a DEPTH=1 instance.
module tb_bubble_sorter;

  import bubble_sorter_pkg::*;

  typedef struct {
    string        name;
    logic [127:0] data;
    logic         desc;
    logic [127:0] exp_data;
    int           exp_swaps;
    int           exp_edges;
  } vec_t;

  localparam logic [127:0] REV    = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] ASC    = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] MIX    = 128'h03070701050500090202080406060103;
  localparam logic [127:0] MIX_D  = 128'h09080707060605050403030202010100;
  localparam logic [127:0] MIX_A  = 128'h00010102020303040505060607070809;
  localparam logic [127:0] EQ5    = 128'h05050505050505050505050505050505;
  localparam logic [127:0] WIDE   = 128'hFF807F0100FE81109020A030B040C050;
  localparam logic [127:0] WIDE_S = 128'h000110203040507F808190A0B0C0FEFF;

  logic        C = 1'b0;
  logic        nRST;
  logic        desc;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  rd_addr;

  logic        start_m;
  logic [7:0]  rd_data_m;
  logic        busy_m;
  logic        done_m;
  logic [15:0] swaps_m;

  logic        start_s;
  logic [7:0]  rd_data_s;
  logic        busy_s;
  logic        done_s;
  logic [3:0]  swaps_s;

  logic        start_o;
  logic        wr_en_o;
  logic [0:0]  addr_o;
  logic [7:0]  rd_data_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] swaps_o;

  int tests = 0;
  int fails = 0;
  vec_t vecs[7];

  always #5 C = ~C;

  bubble_sorter #(.WIDTH(8), .DEPTH(16), .CNTW(16)) dut_m (
    .C(C), .nRST(nRST), .start(start_m), .desc(desc), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data_m), .busy(busy_m), .done(done_m), .swaps(swaps_m)
  );

  bubble_sorter #(.WIDTH(8), .DEPTH(16), .CNTW(4)) dut_s (
    .C(C), .nRST(nRST), .start(start_s), .desc(desc), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data_s), .busy(busy_s), .done(done_s), .swaps(swaps_s)
  );

  bubble_sorter #(.WIDTH(8), .DEPTH(1), .CNTW(16)) dut_o (
    .C(C), .nRST(nRST), .start(start_o), .desc(desc), .wr_en(wr_en_o),
    .wr_addr(addr_o), .wr_data(wr_data), .rd_addr(addr_o),
    .rd_data(rd_data_o), .busy(busy_o), .done(done_o), .swaps(swaps_o)
  );

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] elem(input logic [127:0] v, input int k);
    return v[(15 - k) * 8 +: 8];
  endfunction

  task automatic loadArray(input logic [127:0] vals);
    for (int k = 0; k < 16; k++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(k);
      wr_data = elem(vals, k);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic readCheck(input logic [127:0] exp_vals, input string tag, input bit sat_inst);
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      tick();
      checkOutput($sformatf("%s[%0d]", tag, k),
                  sat_inst ? rd_data_s : rd_data_m, elem(exp_vals, k));
    end
  endtask

  // Start the main instance and count edges (start edge = 1) until done
  task automatic runSort(input logic d, input string tag, output int edges);
    desc    = d;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    edges   = 1;
    checkOutput({tag, "_busy_after_start"}, busy_m, 1);
    while (!done_m && edges < 2000) begin
      tick();
      edges++;
    end
    checkOutput({tag, "_done_seen"}, done_m, 1);
    checkOutput({tag, "_busy_at_done"}, busy_m, 0);
    tick();
    checkOutput({tag, "_done_pulse_end"}, done_m, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int edges;
    loadArray(v.data);
    runSort(v.desc, v.name, edges);
    if (v.exp_swaps >= 0) checkOutput({v.name, "_swaps"}, swaps_m, v.exp_swaps);
    if (v.exp_edges >= 0) checkOutput({v.name, "_edges"}, edges, v.exp_edges);
    readCheck(v.exp_data, v.name, 1'b0);
  endtask

  initial begin
    int edges;

    vecs[0] = '{"rev_asc",    REV,  1'b0, ASC,    120, 721};
    vecs[1] = '{"sorted_asc", ASC,  1'b0, ASC,    0,   61};
    vecs[2] = '{"dup_desc",   MIX,  1'b1, MIX_D,  53,  -1};
    vecs[3] = '{"dup_asc",    MIX,  1'b0, MIX_A,  61,  -1};
    vecs[4] = '{"equal",      EQ5,  1'b0, EQ5,    0,   61};
    vecs[5] = '{"wide_asc",   WIDE, 1'b0, WIDE_S, -1,  -1};
    vecs[6] = '{"rev_desc",   ASC,  1'b1, REV,    120, 721};

    nRST = 1'b0; desc = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    start_m = 1'b0; start_s = 1'b0; start_o = 1'b0; wr_en_o = 1'b0; addr_o = '0;
    tick();
    tick();
    checkOutput("reset_busy", busy_m, 0);
    checkOutput("reset_done", done_m, 0);
    checkOutput("reset_swaps", swaps_m, 0);
    checkOutput("reset_rd_data", rd_data_m, 0);
    nRST = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v]);
    end

    // Reset while in CMP of pass 3 of a reverse-order sort
    loadArray(REV);
    desc    = 1'b0;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    repeat (176) tick();
    checkOutput("abort_point_cmp", (dut_m.state == CMP), 1);
    checkOutput("abort_point_last", dut_m.last, 12);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    checkOutput("abort_busy", busy_m, 0);
    checkOutput("abort_done", done_m, 0);
    checkOutput("abort_swaps", swaps_m, 0);
    checkOutput("abort_rd_data", rd_data_m, 0);
    runSort(1'b0, "after_abort", edges);
    checkOutput("after_abort_swaps", swaps_m, 91);
    readCheck(ASC, "after_abort", 1'b0);

    // Host writes and start pulses while busy are dropped; rd_data holds
    loadArray(MIX);
    rd_addr = 4'd0;
    tick();
    checkOutput("hold_pre_read", rd_data_m, 3);
    desc    = 1'b0;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    edges   = 1;
    while (!done_m && edges < 2000) begin
      start_m = (edges % 7 == 3);
      wr_en   = (edges % 5 == 2);
      wr_addr = 4'(edges % 16);
      wr_data = 8'hEE;
      rd_addr = 4'd5;
      tick();
      edges++;
      if (busy_m && (edges % 40 == 0)) checkOutput("rd_data_hold", rd_data_m, 3);
    end
    start_m = 1'b0;
    wr_en   = 1'b0;
    checkOutput("busy_ign_done_seen", done_m, 1);
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    checkOutput("start_in_done_ignored", busy_m, 0);
    checkOutput("busy_ign_swaps", swaps_m, 61);
    readCheck(MIX_A, "busy_ign", 1'b0);

    // DEPTH=1: start goes straight to DONE
    wr_en_o = 1'b1;
    wr_data = 8'h5A;
    tick();
    wr_en_o = 1'b0;
    start_o = 1'b1;
    tick();
    start_o = 1'b0;
    checkOutput("d1_done", done_o, 1);
    checkOutput("d1_busy", busy_o, 0);
    checkOutput("d1_swaps", swaps_o, 0);
    tick();
    checkOutput("d1_done_pulse_end", done_o, 0);
    tick();
    checkOutput("d1_rd_data", rd_data_o, 8'h5A);

    // CNTW=4 saturates at 15 on a 120-swap sort
    loadArray(REV);
    desc    = 1'b0;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    edges   = 1;
    while (!done_s && edges < 2000) begin
      tick();
      edges++;
    end
    checkOutput("sat_done_seen", done_s, 1);
    checkOutput("sat_swaps", swaps_s, 15);
    tick();
    readCheck(ASC, "sat", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
